// File: rtl/rtc_port_pkg.sv
// Shared definitions for the RTC port responder: default port map, phase timing
// and the bus sequencer state encoding.
package rtc_port_pkg;

    localparam logic [7:0] P_ADDR_DEF  = 8'h01;
    localparam logic [7:0] P_DATA_DEF  = 8'h02;
    localparam logic [7:0] P_CMD_DEF   = 8'h03;
    localparam logic [7:0] P_STAT_DEF  = 8'h04;
    localparam int         T_PHASE_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_A_STB = 3'd1,
        ST_A_REC = 3'd2,
        ST_D_STB = 3'd3,
        ST_D_REC = 3'd4,
        ST_TURN  = 3'd5
    } seq_state_e;

    // Fixed phase order of one bus cycle; TURN hands back to IDLE.
    function automatic seq_state_e next_phase(input seq_state_e s);
        case (s)
            ST_A_STB: next_phase = ST_A_REC;
            ST_A_REC: next_phase = ST_D_STB;
            ST_D_STB: next_phase = ST_D_REC;
            ST_D_REC: next_phase = ST_TURN;
            default:  next_phase = ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/rtc_port_responder_seq.sv
// Multiplexed-bus sequencer for the RTC: FSM, phase counter and strobe generation.
// Optional RTC_IRQ_EN adds a cycle-complete pulse for the interrupt flag.
module rtc_bus_seq
    import rtc_port_pkg::*;
#(
    parameter int T_PHASE = T_PHASE_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       start_rd,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       cap_rdata,
`ifdef RTC_IRQ_EN
    output logic       done,
`endif
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       a_d
);

    localparam int CW = $clog2(T_PHASE + 1);

    seq_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rd_q, rd_d;
    logic          last;

    assign last = (cnt_q == CW'(1));
    assign busy = (state_q != ST_IDLE);
`ifdef RTC_IRQ_EN
    assign done = (state_q == ST_TURN) && last;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
        end
    end

    // The counter is reloaded on every state entry and counts down to 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        if (state_q == ST_IDLE) begin
            if (start) begin
                state_d = ST_A_STB;
                cnt_d   = CW'(T_PHASE);
                rd_d    = start_rd;
            end
        end else if (last) begin
            state_d = next_phase(state_q);
            cnt_d   = (state_q == ST_TURN) ? '0 : CW'(T_PHASE);
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_comb begin
        cs_n      = 1'b1;
        rd_n      = 1'b1;
        wr_n      = 1'b1;
        a_d       = 1'b1;
        ad_oe     = 1'b0;
        ad_out    = 8'h00;
        cap_rdata = 1'b0;
        case (state_q)
            ST_A_STB: begin
                cs_n   = 1'b0;
                wr_n   = 1'b0;
                ad_oe  = 1'b1;
                ad_out = addr;
            end
            ST_A_REC: begin
                cs_n   = 1'b0;
                ad_oe  = 1'b1;
                ad_out = addr;
            end
            ST_D_STB: begin
                cs_n = 1'b0;
                a_d  = 1'b0;
                if (rd_q) begin
                    rd_n      = 1'b0;
                    cap_rdata = last;
                end else begin
                    wr_n   = 1'b0;
                    ad_oe  = 1'b1;
                    ad_out = wdata;
                end
            end
            ST_D_REC: begin
                cs_n = 1'b0;
                a_d  = 1'b0;
                if (!rd_q) begin
                    ad_oe  = 1'b1;
                    ad_out = wdata;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rtc_port_responder.sv
// Processor port responder for a multiplexed-bus RTC: port decode, registers,
// in_port mux and overrun flag. Optional macro RTC_IRQ_EN adds interrupt/interrupt_ack.
module rtc_port_responder
    import rtc_port_pkg::*;
#(
    parameter logic [7:0] P_ADDR  = P_ADDR_DEF,
    parameter logic [7:0] P_DATA  = P_DATA_DEF,
    parameter logic [7:0] P_CMD   = P_CMD_DEF,
    parameter logic [7:0] P_STAT  = P_STAT_DEF,
    parameter int         T_PHASE = T_PHASE_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       write_strobe,
    input  logic       read_strobe,
    output logic [7:0] in_port,
`ifdef RTC_IRQ_EN
    output logic       interrupt,
    input  logic       interrupt_ack,
`endif
    output logic [7:0] rtc_ad_out,
    output logic       rtc_ad_oe,
    input  logic [7:0] rtc_ad_in,
    output logic       rtc_cs_n,
    output logic       rtc_rd_n,
    output logic       rtc_wr_n,
    output logic       rtc_a_d
);

    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic [7:0] in_port_q, in_port_d;
    logic       ovr_q, ovr_d;
    logic       busy, cap_rdata;
    logic       wr_addr, wr_data, wr_cmd, wr_any, accept;

    assign wr_addr = write_strobe && (port_id == P_ADDR);
    assign wr_data = write_strobe && (port_id == P_DATA);
    assign wr_cmd  = write_strobe && (port_id == P_CMD);
    assign wr_any  = wr_addr || wr_data || wr_cmd;
    assign accept  = wr_any && !busy;
    assign in_port = in_port_q;

`ifdef RTC_IRQ_EN
    logic done, irq_q, irq_d;
    assign interrupt = irq_q;
`endif

    rtc_bus_seq #(.T_PHASE(T_PHASE)) u_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (accept && (wr_data || wr_cmd)),
        .start_rd  (wr_cmd),
        .addr      (addr_q),
        .wdata     (wdata_q),
        .busy      (busy),
        .cap_rdata (cap_rdata),
`ifdef RTC_IRQ_EN
        .done      (done),
`endif
        .ad_out    (rtc_ad_out),
        .ad_oe     (rtc_ad_oe),
        .cs_n      (rtc_cs_n),
        .rd_n      (rtc_rd_n),
        .wr_n      (rtc_wr_n),
        .a_d       (rtc_a_d)
    );

    always_comb begin
        addr_d  = (accept && wr_addr) ? out_port : addr_q;
        wdata_d = (accept && wr_data) ? out_port : wdata_q;
        rdata_d = cap_rdata ? rtc_ad_in : rdata_q;
        // An ignored write sets the flag even when a status read clears it.
        if (wr_any && busy) begin
            ovr_d = 1'b1;
        end else if (read_strobe && (port_id == P_STAT)) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
        if (port_id == P_DATA) begin
            in_port_d = rdata_q;
        end else if (port_id == P_STAT) begin
            in_port_d = {6'b0, ovr_q, busy};
        end else if (port_id == P_ADDR) begin
            in_port_d = addr_q;
        end else begin
            in_port_d = 8'h00;
        end
`ifdef RTC_IRQ_EN
        irq_d = done ? 1'b1 : (interrupt_ack ? 1'b0 : irq_q);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= 8'h00;
            wdata_q   <= 8'h00;
            rdata_q   <= 8'h00;
            in_port_q <= 8'h00;
            ovr_q     <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            in_port_q <= in_port_d;
            ovr_q     <= ovr_d;
        end
    end

`ifdef RTC_IRQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end
`endif

endmodule

// File: tb/tb_rtc_port_responder.sv
// Scoreboard bench for rtc_port_responder: directed scenarios plus random port
// traffic against a transaction-level model of the processor-visible behaviour.
module tb_rtc_port_responder;

  localparam int T = 4;
  localparam logic [7:0] PA = 8'h01;
  localparam logic [7:0] PD = 8'h02;
  localparam logic [7:0] PC = 8'h03;
  localparam logic [7:0] PS = 8'h04;

  typedef struct packed {
    logic       rd;
    logic [7:0] addr;
    logic [7:0] data;
  } txn_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] in_port;
  logic [7:0] rtc_ad_out;
  logic       rtc_ad_oe;
  logic [7:0] rtc_ad_in;
  logic       rtc_cs_n;
  logic       rtc_rd_n;
  logic       rtc_wr_n;
  logic       rtc_a_d;
`ifdef RTC_IRQ_EN
  logic       interrupt;
  logic       interrupt_ack;
  logic       m_irq;
  logic       ack_in;
`endif

  logic [7:0] exp_q[$];
  txn_t       txn_q[$];
  int         n_vec;
  int         n_err;

  // Reference model: processor-visible registers and remaining busy clocks.
  logic [7:0] m_addr, m_wdata, m_rdata, bus_in;
  logic       m_ovr, m_rd_op;
  int         busy_left;

  rtc_port_responder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .port_id      (port_id),
    .out_port     (out_port),
    .write_strobe (write_strobe),
    .read_strobe  (read_strobe),
    .in_port      (in_port),
`ifdef RTC_IRQ_EN
    .interrupt    (interrupt),
    .interrupt_ack(interrupt_ack),
`endif
    .rtc_ad_out   (rtc_ad_out),
    .rtc_ad_oe    (rtc_ad_oe),
    .rtc_ad_in    (rtc_ad_in),
    .rtc_cs_n     (rtc_cs_n),
    .rtc_rd_n     (rtc_rd_n),
    .rtc_wr_n     (rtc_wr_n),
    .rtc_a_d      (rtc_a_d)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_addr = 8'h00; m_wdata = 8'h00; m_rdata = 8'h00;
    m_ovr = 1'b0; m_rd_op = 1'b0; busy_left = 0;
`ifdef RTC_IRQ_EN
    m_irq = 1'b0; ack_in = 1'b0;
`endif
  endtask

  // driver: one processor cycle, model advanced across the same edge
  task automatic drive(input logic ws, input logic rs, input logic [7:0] pid, input logic [7:0] dat);
    logic is_cmd;
    logic acc;
    @(negedge clk);
    write_strobe = ws;
    read_strobe  = rs;
    port_id      = pid;
    out_port     = dat;
    rtc_ad_in    = bus_in;
`ifdef RTC_IRQ_EN
    interrupt_ack = ack_in;
    if (busy_left == 1) m_irq = 1'b1;
    else if (ack_in) m_irq = 1'b0;
`endif
    if (rs) begin
      if (pid == PD) exp_q.push_back(m_rdata);
      else if (pid == PS) exp_q.push_back({6'b0, m_ovr, busy_left != 0});
      else if (pid == PA) exp_q.push_back(m_addr);
      else exp_q.push_back(8'h00);
    end
    is_cmd = ws && (pid == PA || pid == PD || pid == PC);
    acc = is_cmd && busy_left == 0;
    if (m_rd_op && busy_left == 2 * T + 1) m_rdata = bus_in;
    if (is_cmd && busy_left != 0) m_ovr = 1'b1;
    else if (rs && pid == PS) m_ovr = 1'b0;
    if (acc && pid == PA) m_addr = dat;
    if (acc && pid == PD) begin
      m_wdata = dat;
      txn_q.push_back('{rd: 1'b0, addr: m_addr, data: dat});
    end
    if (acc && pid == PC) txn_q.push_back('{rd: 1'b1, addr: m_addr, data: 8'h00});
    if (acc && pid != PA) begin
      busy_left = 5 * T;
      m_rd_op = (pid == PC);
    end else if (busy_left > 0) begin
      busy_left--;
    end
    @(posedge clk);
`ifdef RTC_IRQ_EN
    #1 chk("interrupt", int'(interrupt), int'(m_irq));
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  // monitor: processor read responses, one cycle after each read_strobe
  logic rd_seen;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_seen <= 1'b0;
    else rd_seen <= read_strobe;
  end

  always @(negedge clk) begin
    if (rst_n && rd_seen) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL in_port: response %0h with no expectation", in_port);
      end else begin
        chk("in_port", int'(in_port), int'(exp_q.pop_front()));
      end
    end
  end

  // monitor: RTC bus cycles, summarised and compared when cs_n rises
  int   cs_cnt, a_cnt, d_cnt, r_cnt, bad_cnt;
  logic [7:0] a_val, d_val;
  logic cs_prev;
  always @(negedge clk) begin
    if (!rst_n) begin
      cs_cnt = 0; a_cnt = 0; d_cnt = 0; r_cnt = 0; bad_cnt = 0; cs_prev = 1'b1;
    end else begin
      if (!rtc_cs_n) begin
        cs_cnt++;
        if (rtc_a_d && !rtc_wr_n && rtc_ad_oe) begin
          if (a_cnt > 0 && rtc_ad_out != a_val) bad_cnt++;
          a_val = rtc_ad_out; a_cnt++;
        end
        if (!rtc_a_d && !rtc_wr_n && rtc_ad_oe) begin
          if (d_cnt > 0 && rtc_ad_out != d_val) bad_cnt++;
          d_val = rtc_ad_out; d_cnt++;
        end
        if (!rtc_rd_n) begin
          r_cnt++;
          if (rtc_ad_oe || rtc_a_d) bad_cnt++;
        end
      end else if (!cs_prev) begin
        if (txn_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL bus_cycle: unexpected cycle addr %0h", a_val);
        end else begin
          txn_t t;
          t = txn_q.pop_front();
          chk("cs_low_clocks", cs_cnt, 4 * T);
          chk("addr_wr_clocks", a_cnt, T);
          chk("addr_value", int'(a_val), int'(t.addr));
          chk("bus_glitch", bad_cnt, 0);
          chk("data_wr_clocks", d_cnt, t.rd ? 0 : T);
          chk("rd_clocks", r_cnt, t.rd ? T : 0);
          if (!t.rd) chk("data_value", int'(d_val), int'(t.data));
        end
        cs_cnt = 0; a_cnt = 0; d_cnt = 0; r_cnt = 0; bad_cnt = 0;
      end else if (rtc_ad_oe || !rtc_rd_n || !rtc_wr_n) begin
        n_vec++; n_err++;
        $display("FAIL idle_bus: oe %0b rd_n %0b wr_n %0b with cs_n high", rtc_ad_oe, rtc_rd_n, rtc_wr_n);
      end
      cs_prev = rtc_cs_n;
    end
  end

  task automatic check_reset_pins(input string tag);
    chk({tag, "_cs_n"}, int'(rtc_cs_n), 1);
    chk({tag, "_rd_n"}, int'(rtc_rd_n), 1);
    chk({tag, "_wr_n"}, int'(rtc_wr_n), 1);
    chk({tag, "_oe"}, int'(rtc_ad_oe), 0);
    chk({tag, "_in_port"}, int'(in_port), 0);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; write_strobe = 1'b0; read_strobe = 1'b0;
    port_id = 8'h00; out_port = 8'h00; rtc_ad_in = 8'h00; bus_in = 8'h00;
`ifdef RTC_IRQ_EN
    interrupt_ack = 1'b0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_reset_pins("reset");
    chk("reset_a_d", int'(rtc_a_d), 1);
    chk("reset_ad_out", int'(rtc_ad_out), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // write cycle on the first edge after reset, status polled every clock
    drive(1'b1, 1'b0, PA, 8'h21);
    drive(1'b1, 1'b0, PD, 8'h45);
    for (int i = 0; i < 22; i++) drive(1'b0, 1'b1, PS, 8'h00);

    // read cycle returning 8'h59
    bus_in = 8'h59;
    drive(1'b1, 1'b0, PC, 8'h00);
    idle(5 * T);
    drive(1'b0, 1'b1, PD, 8'h00);

    // ignored write while busy sets ovr; status read clears it
    drive(1'b1, 1'b0, PA, 8'h11);
    drive(1'b1, 1'b0, PD, 8'h77);
    drive(1'b1, 1'b0, PA, 8'h33);
    drive(1'b0, 1'b1, PS, 8'h00);
    drive(1'b0, 1'b1, PS, 8'h00);
    idle(5 * T);
    drive(1'b0, 1'b1, PS, 8'h00);
    drive(1'b0, 1'b1, PA, 8'h00);

    // back-to-back commands on the first clock after TURN
    bus_in = 8'hA6;
    drive(1'b1, 1'b0, PC, 8'h00);
    while (busy_left != 0) drive(1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, PD, 8'h3C);
    drive(1'b0, 1'b1, PS, 8'h00);
    idle(5 * T);
    drive(1'b0, 1'b1, PD, 8'h00);

    // asynchronous reset at clock 7 of a write cycle
    drive(1'b1, 1'b0, PD, 8'h5A);
    idle(6);
    #2 rst_n = 1'b0;
    write_strobe = 1'b0; read_strobe = 1'b0;
    #1 check_reset_pins("midreset");
    model_reset();
    txn_q.delete();
    exp_q.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    drive(1'b0, 1'b1, PA, 8'h00);
    drive(1'b0, 1'b1, PD, 8'h00);
    drive(1'b0, 1'b1, PS, 8'h00);

    // random port traffic
    for (int i = 0; i < 600; i++) begin
      logic [7:0] pid;
      int r;
      r = $urandom_range(0, 6);
      pid = (r < 5) ? 8'(r) : 8'($urandom);
      bus_in = 8'($urandom);
`ifdef RTC_IRQ_EN
      ack_in = ($urandom_range(0, 7) == 0);
`endif
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, pid, 8'($urandom));
    end
`ifdef RTC_IRQ_EN
    ack_in = 1'b0;
`endif

    // drain
    while (busy_left != 0) drive(1'b0, 1'b0, 8'h00, 8'h00);
    idle(3);
    chk("txn_q_empty", txn_q.size(), 0);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
